// File: rtl/fb_pkg.sv
// Shared framebuffer layout for the HUB75 pixel writer and the panel scan engine.
// One RAM word holds the top-half pixel in [17:9] and the bottom-half pixel in [8:0].
package fb_pkg;

    localparam int COLS      = 160;
    localparam int HALF_ROWS = 20;
    localparam int CDEPTH    = 3;
    localparam int ADDR_W    = 12;
    localparam int WORD_W    = 36;

    localparam int PIX_W     = 3 * CDEPTH;
    localparam int TOP_LSB   = 9;
    localparam int BOT_LSB   = 0;
    localparam int PAD_LSB   = 2 * PIX_W;
    localparam int NUM_WORDS = COLS * HALF_ROWS;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        WAIT  = 3'd2,
        WR    = 3'd3,
        CLEAR = 3'd4
    } state_e;

endpackage

// File: rtl/fb_addr_map.sv
// Maps a pixel coordinate to its framebuffer word address and half select.
// COLS*row is built from shifts (128 + 32) so no multiplier is needed.
module fb_addr_map
    import fb_pkg::*;
(
    input  logic [7:0]        i_x,
    input  logic [5:0]        i_y,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_half,
    output logic              o_oob
);

    logic [5:0]        row;
    logic [ADDR_W-1:0] row_w;

    always_comb begin
        o_half = (i_y >= 6'(HALF_ROWS));
        row    = o_half ? (i_y - 6'(HALF_ROWS)) : i_y;
        row_w  = ADDR_W'(row);
        o_addr = ADDR_W'(i_x) + (row_w << 7) + (row_w << 5);
        o_oob  = (i_x >= 8'(COLS)) || (i_y >= 6'(2 * HALF_ROWS));
    end

endmodule

// File: rtl/fb_pixel_writer.sv
// Framebuffer write controller: read-modify-write of packed pixel pairs plus full-frame fill.
// Handshake: a pixel transfers on a rising edge where i_valid && o_ready; inputs are captured then.
module fb_pixel_writer
    import fb_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [7:0]        i_x,
    input  logic [5:0]        i_y,
    input  logic [8:0]        i_rgb,
    input  logic              i_clear,
    input  logic [8:0]        i_clear_rgb,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err_oob,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_rd_en,
    input  logic [WORD_W-1:0] i_rd_data,
    output logic              o_wr_en,
    output logic [WORD_W-1:0] o_wr_data
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              half_q, half_d;
    logic [PIX_W-1:0]  rgb_q, rgb_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              pend_q, pend_d;
    logic [PIX_W-1:0]  crgb_q, crgb_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] map_addr;
    logic              map_half;
    logic              map_oob;
    logic              transfer;
    logic [WORD_W-1:0] merged;

    fb_addr_map u_addr_map (
        .i_x    (i_x),
        .i_y    (i_y),
        .o_addr (map_addr),
        .o_half (map_half),
        .o_oob  (map_oob)
    );

    assign o_ready   = (state_q == IDLE) && !pend_q && !i_clear;
    assign transfer  = i_valid && o_ready;
    assign o_busy    = (state_q != IDLE) || pend_q;
    assign o_done    = done_q;
    assign o_err_oob = err_q;

    // The untouched half of the read word is kept; the pad bits above it are masked off.
    always_comb begin
        merged = word_q & {{(WORD_W - PAD_LSB){1'b0}}, {PAD_LSB{1'b1}}};
        if (half_q) begin
            merged[BOT_LSB +: PIX_W] = rgb_q;
        end else begin
            merged[TOP_LSB +: PIX_W] = rgb_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        half_d    = half_q;
        rgb_d     = rgb_q;
        word_d    = word_q;
        pend_d    = pend_q;
        crgb_d    = crgb_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        o_rd_en   = 1'b0;
        o_wr_en   = 1'b0;
        o_addr    = '0;
        o_wr_data = '0;

        // A clear seen mid-pixel is remembered; the first requested colour sticks.
        if ((state_q == RD || state_q == WAIT || state_q == WR) && i_clear && !pend_q) begin
            pend_d = 1'b1;
            crgb_d = i_clear_rgb;
        end

        case (state_q)
            IDLE: begin
                if (pend_q || i_clear) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                    if (!pend_q) begin
                        crgb_d = i_clear_rgb;
                    end
                end else if (transfer) begin
                    if (map_oob) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = RD;
                        addr_d  = map_addr;
                        half_d  = map_half;
                        rgb_d   = i_rgb;
                    end
                end
            end
            RD: begin
                o_rd_en = 1'b1;
                o_addr  = addr_q;
                state_d = WAIT;
            end
            WAIT: begin
                word_d  = i_rd_data;
                state_d = WR;
            end
            WR: begin
                o_wr_en   = 1'b1;
                o_addr    = addr_q;
                o_wr_data = merged;
                state_d   = IDLE;
            end
            CLEAR: begin
                o_wr_en   = 1'b1;
                o_addr    = cnt_q;
                o_wr_data = {{(WORD_W - PAD_LSB){1'b0}}, crgb_q, crgb_q};
                cnt_d     = cnt_q + ADDR_W'(1);
                if (cnt_q == ADDR_W'(NUM_WORDS - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            half_q  <= 1'b0;
            rgb_q   <= '0;
            word_q  <= '0;
            pend_q  <= 1'b0;
            crgb_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            half_q  <= half_d;
            rgb_q   <= rgb_d;
            word_q  <= word_d;
            pend_q  <= pend_d;
            crgb_q  <= crgb_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Bench for fb_pixel_writer: RAM model on the write/read ports and a pixel-level framebuffer reference.
// The reference stores colours per (x, y); RAM words are derived from it by the documented packing.
module tb_fb_pixel_writer;

    logic        clk;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [7:0]  i_x;
    logic [5:0]  i_y;
    logic [8:0]  i_rgb;
    logic        i_clear;
    logic [8:0]  i_clear_rgb;
    logic        o_busy;
    logic        o_done;
    logic        o_err_oob;
    logic [11:0] o_addr;
    logic        o_rd_en;
    logic [35:0] rd_data;
    logic        o_wr_en;
    logic [35:0] o_wr_data;

    logic [35:0] ram [0:4095];
    logic [8:0]  fb  [0:159][0:39];

    int n_assert = 0;
    int n_fail   = 0;
    int overlap  = 0;

    fb_pixel_writer dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_x         (i_x),
        .i_y         (i_y),
        .i_rgb       (i_rgb),
        .i_clear     (i_clear),
        .i_clear_rgb (i_clear_rgb),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err_oob   (o_err_oob),
        .o_addr      (o_addr),
        .o_rd_en     (o_rd_en),
        .i_rd_data   (rd_data),
        .o_wr_en     (o_wr_en),
        .o_wr_data   (o_wr_data)
    );

    // clock / reset-free RAM model with one-cycle read latency
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_wr_en) ram[o_addr] <= o_wr_data;
        if (o_rd_en) rd_data <= ram[o_addr];
    end

    always @(negedge clk) begin
        if (!i_rst && o_rd_en && o_wr_en) overlap++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [35:0] exp_word(input int a);
        int x;
        int r;
        x = a % 160;
        r = a / 160;
        return {18'b0, fb[x][r], fb[x][r + 20]};
    endfunction

    function automatic int addr_of(input int x, input int y);
        return x + 160 * (y % 20);
    endfunction

    task automatic model_fill(input int upto, input logic [8:0] c);
        for (int a = 0; a < upto; a++) begin
            fb[a % 160][a / 160]      = c;
            fb[a % 160][a / 160 + 20] = c;
        end
    endtask

    task automatic compare_all(input string tag);
        int bad = 0;
        for (int a = 0; a < 3200; a++) begin
            if (ram[a] !== exp_word(a)) bad++;
        end
        check(tag, 64'(bad), 64'd0);
    endtask

    // Caller is just after a negedge. Optionally raises i_clear while the pixel is in RD.
    task automatic pixel_checked(input int x, input int y, input logic [8:0] rgb,
                                 input bit clr_mid, input logic [8:0] clr);
        int w = 0;
        int a;
        i_x = 8'(x); i_y = 6'(y); i_rgb = rgb; i_valid = 1'b1;
        #1;
        while (!o_ready && w < 5000) begin
            @(negedge clk); #1; w++;
        end
        check("pix_accept_timeout", 64'(w < 5000), 64'd1);
        if (w >= 5000) begin
            i_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        i_valid = 1'b0;
        i_x = 8'($urandom); i_y = 6'($urandom); i_rgb = 9'($urandom);
        if (clr_mid) begin
            i_clear = 1'b1; i_clear_rgb = clr;
        end
        fb[x][y] = rgb;
        a = addr_of(x, y);
        @(negedge clk);
        check("pix_rd_en", 64'(o_rd_en), 64'd1);
        check("pix_rd_addr", 64'(o_addr), 64'(a));
        check("pix_rd_no_wr", 64'(o_wr_en), 64'd0);
        check("pix_busy_ready", 64'({o_busy, o_ready}), 64'b10);
        if (clr_mid) begin
            @(posedge clk); #1;
            i_clear = 1'b0; i_clear_rgb = 9'($urandom);
        end
        @(negedge clk);
        check("pix_wait_idle_bus", 64'({o_rd_en, o_wr_en}), 64'b00);
        @(negedge clk);
        check("pix_wr_en", 64'({o_wr_en, o_rd_en}), 64'b10);
        check("pix_wr_addr", 64'(o_addr), 64'(a));
        check("pix_wr_data", 64'(o_wr_data), 64'(exp_word(a)));
        @(negedge clk);
        check("pix_ready_after_4", 64'(o_ready), 64'(!clr_mid));
        check("pix_busy_after", 64'(o_busy), 64'(clr_mid));
        check("pix_bus_quiet", 64'({o_rd_en, o_wr_en}), 64'b00);
    endtask

    task automatic oob_checked(input int x, input int y);
        i_x = 8'(x); i_y = 6'(y); i_rgb = 9'($urandom); i_valid = 1'b1;
        #1;
        check("oob_ready_before", 64'(o_ready), 64'd1);
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(negedge clk);
        check("oob_err_pulse", 64'(o_err_oob), 64'd1);
        check("oob_no_ram", 64'({o_rd_en, o_wr_en}), 64'b00);
        check("oob_ready_next", 64'(o_ready), 64'd1);
        @(negedge clk);
        check("oob_err_one_cycle", 64'(o_err_oob), 64'd0);
        check("oob_no_ram_2", 64'({o_rd_en, o_wr_en}), 64'b00);
    endtask

    // Called right after the edge that starts the clear; returns at the o_done negedge (+#1).
    task automatic watch_clear(input logic [8:0] c);
        int n = 0;
        int bad = 0;
        int cyc = 0;
        bit got_done = 0;
        logic [35:0] expw;
        expw = {18'b0, c, c};
        while (!got_done && cyc < 4000) begin
            @(negedge clk); #1; cyc++;
            if (cyc == 100) begin
                i_clear = 1'b1; i_clear_rgb = ~c;
            end else if (cyc == 101) begin
                i_clear = 1'b0;
            end
            if (o_done) begin
                got_done = 1;
                check("clear_write_count", 64'(n), 64'd3200);
                check("clear_done_busy", 64'({o_busy, o_wr_en}), 64'b00);
            end else begin
                if (!(o_wr_en && !o_rd_en && o_addr == 12'(n) && o_wr_data === expw
                      && o_busy && !o_ready)) bad++;
                n++;
            end
        end
        check("clear_done_seen", 64'(got_done), 64'd1);
        check("clear_bad_cycles", 64'(bad), 64'd0);
        model_fill(3200, c);
    endtask

    task automatic random_pixels(input int count);
        for (int k = 0; k < count; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 0) oob_checked($urandom_range(160, 255), $urandom_range(0, 39));
                else oob_checked($urandom_range(0, 159), $urandom_range(40, 63));
            end else begin
                pixel_checked($urandom_range(0, 159), $urandom_range(0, 39), 9'($urandom), 1'b0, 9'd0);
            end
        end
    endtask

    initial begin
        logic [8:0] c;
        logic [8:0] p;
        int w;
        i_rst = 1'b1; i_valid = 1'b0; i_x = '0; i_y = '0; i_rgb = '0;
        i_clear = 1'b0; i_clear_rgb = '0; rd_data = '0;
        for (int a = 0; a < 4096; a++) ram[a] = '0;
        for (int x = 0; x < 160; x++) for (int y = 0; y < 40; y++) fb[x][y] = '0;
        ram[485] = 36'h2A;
        fb[5][23] = 9'h02A;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'(o_ready), 64'd1);
        check("rst_flags", 64'({o_busy, o_done, o_err_oob}), 64'b000);
        check("rst_strobes", 64'({o_rd_en, o_wr_en}), 64'b00);
        check("rst_addr", 64'(o_addr), 64'd0);
        check("rst_wr_data", 64'(o_wr_data), 64'd0);
        i_rst = 1'b0;

        // directed read-modify-writes of the preloaded word
        @(negedge clk);
        pixel_checked(5, 3, 9'b110_010_100, 1'b0, 9'd0);
        check("dir_top_word", 64'(exp_word(485)), 64'h3282A);
        pixel_checked(5, 23, 9'b001_001_001, 1'b0, 9'd0);
        check("dir_bot_word", 64'(exp_word(485)), 64'h32849);

        @(negedge clk);
        oob_checked(160, 0);
        oob_checked(0, 40);

        random_pixels(40);
        compare_all("ram_after_pixels");

        // full fill
        @(negedge clk);
        i_clear = 1'b1; i_clear_rgb = 9'b111_000_000;
        #1;
        check("clear_blocks_ready", 64'(o_ready), 64'd0);
        @(posedge clk); #1;
        i_clear = 1'b0; i_clear_rgb = 9'($urandom);
        watch_clear(9'b111_000_000);
        compare_all("ram_after_fill");

        // clear request while a pixel is in flight
        @(negedge clk);
        c = 9'($urandom);
        pixel_checked($urandom_range(0, 159), $urandom_range(0, 39), 9'($urandom), 1'b1, c);
        @(posedge clk); #1;
        watch_clear(c);
        compare_all("ram_after_pending_fill");

        // clear and pixel in the same cycle: clear first, pixel held until o_done
        @(negedge clk);
        c = 9'($urandom); p = 9'($urandom);
        i_clear = 1'b1; i_clear_rgb = c;
        i_valid = 1'b1; i_x = 8'd0; i_y = 6'd0; i_rgb = p;
        #1;
        check("clr_vs_pix_ready", 64'(o_ready), 64'd0);
        @(posedge clk); #1;
        i_clear = 1'b0;
        watch_clear(c);
        pixel_checked(0, 0, p, 1'b0, 9'd0);
        check("clr_vs_pix_ram0", 64'(ram[0]), 64'({18'b0, p, c}));
        compare_all("ram_after_clr_vs_pix");

        random_pixels(20);

        // reset in the middle of a fill
        @(negedge clk);
        c = 9'($urandom);
        i_clear = 1'b1; i_clear_rgb = c;
        @(posedge clk); #1;
        i_clear = 1'b0;
        w = 0;
        do begin
            @(negedge clk); #1; w++;
        end while (!(o_wr_en && o_addr == 12'd999) && w < 2000);
        check("rst_mid_reach_999", 64'({o_wr_en, o_addr}), 64'({1'b1, 12'd999}));
        i_rst = 1'b1;
        @(posedge clk); #1;
        i_rst = 1'b0;
        model_fill(1000, c);
        @(negedge clk);
        check("rst_mid_strobes", 64'({o_wr_en, o_rd_en}), 64'b00);
        check("rst_mid_ready_busy", 64'({o_ready, o_busy}), 64'b10);
        w = 0;
        repeat (6) begin
            @(negedge clk);
            if (o_done || o_wr_en) w++;
        end
        check("rst_mid_no_done", 64'(w), 64'd0);
        compare_all("ram_after_rst_mid");

        random_pixels(20);
        compare_all("ram_final");
        check("rd_wr_overlap", 64'(overlap), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
